// File: rtl/lut_sweep_engine_if.sv
// ---------------------------------------------------------------------------
// lut_sweep_engine_if
// Groups the configuration, sweep-control, direct-evaluation and result
// signals of lut_sweep_engine into one bundle.
//   master : drives cfg_we/cfg_sel/cfg_data, start, eval_in; observes results
//   slave  : the engine itself
// Ports carried:
//   cfg_we, cfg_sel[SEL_W], cfg_data[ROWS]  table write (bit r = f(r))
//   start                                   sweep request
//   eval_in[N_IN] -> eval_out[N_FN]         registered direct evaluation
//   busy, row_valid, row_idx, row_out, done sweep progress and row stream
//   counts[N_FN*CW]                         minterm count k at [k*CW +: CW]
// ---------------------------------------------------------------------------
interface lut_sweep_engine_if #(
    parameter int N_IN = 4,
    parameter int N_FN = 10
);
    localparam int ROWS  = 1 << N_IN;
    localparam int SEL_W = (N_FN > 1) ? $clog2(N_FN) : 1;
    localparam int CW    = N_IN + 1;

    logic                 cfg_we;
    logic [SEL_W-1:0]     cfg_sel;
    logic [ROWS-1:0]      cfg_data;
    logic                 start;
    logic [N_IN-1:0]      eval_in;
    logic [N_FN-1:0]      eval_out;
    logic                 busy;
    logic                 row_valid;
    logic [N_IN-1:0]      row_idx;
    logic [N_FN-1:0]      row_out;
    logic                 done;
    logic [N_FN*CW-1:0]   counts;

    modport master (
        output cfg_we, cfg_sel, cfg_data, start, eval_in,
        input  eval_out, busy, row_valid, row_idx, row_out, done, counts
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_data, start, eval_in,
        output eval_out, busy, row_valid, row_idx, row_out, done, counts
    );
endinterface

// File: rtl/lut_sweep_engine.sv
// ---------------------------------------------------------------------------
// lut_sweep_engine
// Holds N_FN loadable truth tables of N_IN inputs. Every cycle it evaluates
// all tables at eval_in (registered, 1-cycle latency). On start it sweeps
// all ROWS input rows, one per cycle, streaming row_idx/row_out and
// accumulating per-function minterm counts; done pulses with the last row.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears tables, counts, outputs)
//   bus    lut_sweep_engine_if.slave bundle (see interface header)
// ---------------------------------------------------------------------------
module lut_sweep_engine #(
    parameter int N_IN = 4,
    parameter int N_FN = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lut_sweep_engine_if.slave     bus
);
    localparam int ROWS  = 1 << N_IN;
    localparam int SEL_W = (N_FN > 1) ? $clog2(N_FN) : 1;
    localparam int CW    = N_IN + 1;

    // One extra bit so an out-of-range select (e.g. 12 with 10 functions)
    // compares correctly against the function count.
    localparam logic [SEL_W:0]  FN_LIMIT = (SEL_W+1)'(N_FN);
    localparam logic [N_IN-1:0] LAST_ROW = N_IN'(ROWS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_sweep_start;
    logic            w_last_row;
    logic            w_cfg_accept;

    logic [N_IN-1:0] r_idx;
    logic [N_IN-1:0] r_row_idx;
    logic            r_busy;
    logic            r_row_valid;
    logic            r_done;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_sweep_start = 1'b0;
        w_last_row    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next  = ST_SWEEP;
                    w_sweep_start = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (r_idx == LAST_ROW) begin
                    w_state_next = ST_IDLE;
                    w_last_row   = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Writes only land while idle, so a sweep always sees a stable table.
    // A write on the start edge is still idle and therefore lands before row 0.
    assign w_cfg_accept = (r_state == ST_IDLE) && bus.cfg_we &&
                          ({1'b0, bus.cfg_sel} < FN_LIMIT);

    // ---------------- sweep sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_row_idx   <= '0;
            r_busy      <= 1'b0;
            r_row_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy      <= (w_state_next == ST_SWEEP);
            r_row_valid <= (r_state == ST_SWEEP);
            r_done      <= w_last_row;
            if (w_sweep_start) begin
                r_idx <= '0;
            end else if ((r_state == ST_SWEEP) && !w_last_row) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == ST_SWEEP) begin
                r_row_idx <= r_idx;
            end
        end
    end

    // ---------------- per-function table, evaluation and count ----------------
    genvar gi;
    generate
        for (gi = 0; gi < N_FN; gi++) begin : g_fn
            localparam logic [SEL_W-1:0] FN_SEL = SEL_W'(gi);

            logic [ROWS-1:0] r_table;
            logic            r_eval;
            logic            r_row_bit;
            logic [CW-1:0]   r_count;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_table   <= '0;
                    r_eval    <= 1'b0;
                    r_row_bit <= 1'b0;
                    r_count   <= '0;
                end else begin
                    if (w_cfg_accept && (bus.cfg_sel == FN_SEL)) begin
                        r_table <= bus.cfg_data;
                    end
                    r_eval <= r_table[bus.eval_in];
                    if (w_sweep_start) begin
                        r_count <= '0;
                    end else if (r_state == ST_SWEEP) begin
                        r_row_bit <= r_table[r_idx];
                        // CW = N_IN+1 bits holds ROWS, so no saturation.
                        r_count   <= r_count + CW'(r_table[r_idx]);
                    end
                end
            end

            assign bus.eval_out[gi]           = r_eval;
            assign bus.row_out[gi]            = r_row_bit;
            assign bus.counts[gi*CW +: CW]    = r_count;
        end
    endgenerate

    assign bus.busy      = r_busy;
    assign bus.row_valid = r_row_valid;
    assign bus.row_idx   = r_row_idx;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_lut_sweep_engine.sv
// ---------------------------------------------------------------------------
// tb_lut_sweep_engine
// Scoreboard bench: the reference model pushes expected rows and final
// counts when a sweep is accepted; a monitor on the falling edge pops and
// compares whatever the engine presents.
// ---------------------------------------------------------------------------
module tb_lut_sweep_engine;
    localparam int N_IN  = 4;
    localparam int N_FN  = 10;
    localparam int ROWS  = 16;
    localparam int CW    = 5;

    typedef struct {
        int                 cyc;
        logic [N_IN-1:0]    idx;
        logic [N_FN-1:0]    val;
    } row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lut_sweep_engine_if #(.N_IN(N_IN), .N_FN(N_FN)) b ();

    lut_sweep_engine #(.N_IN(N_IN), .N_FN(N_FN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit rand_eval = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [ROWS-1:0]      m_table [N_FN];
    int                   m_rem = 0;       // rows still to come in current sweep
    int                   m_cyc = 0;
    logic [N_FN*CW-1:0]   m_counts = '0;
    logic [N_FN*CW-1:0]   m_final  = '0;
    logic [N_FN-1:0]      exp_eval = '0;
    logic                 exp_busy = 1'b0;
    logic                 exp_row_valid = 1'b0;
    logic                 exp_done = 1'b0;
    row_t                 row_q [$];
    logic [N_FN*CW-1:0]   cnt_q [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_FN; k++) m_table[k] = '0;
            m_rem = 0; m_counts = '0; m_final = '0;
            exp_eval = '0; exp_busy = 1'b0; exp_row_valid = 1'b0; exp_done = 1'b0;
            row_q.delete(); cnt_q.delete();
        end else begin
            m_cyc++;
            for (int k = 0; k < N_FN; k++) exp_eval[k] = m_table[k][b.eval_in];
            exp_row_valid = (m_rem > 0);
            exp_done      = (m_rem == 1);
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) m_counts = m_final;
            end else begin
                if (b.cfg_we && (int'(b.cfg_sel) < N_FN)) m_table[b.cfg_sel] = b.cfg_data;
                if (b.start) begin
                    m_rem = ROWS;
                    for (int r = 0; r < ROWS; r++) begin
                        row_t e;
                        e.cyc = m_cyc + 1 + r;
                        e.idx = 4'(r);
                        for (int k = 0; k < N_FN; k++) e.val[k] = m_table[k][r];
                        row_q.push_back(e);
                    end
                    for (int k = 0; k < N_FN; k++) m_final[k*CW +: CW] = 5'($countones(m_table[k]));
                    cnt_q.push_back(m_final);
                    m_counts = '0;
                end
            end
            exp_busy = (m_rem > 0);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("eval_out", 64'(b.eval_out), 64'(exp_eval));
            chk("busy", 64'(b.busy), 64'(exp_busy));
            chk("row_valid", 64'(b.row_valid), 64'(exp_row_valid));
            chk("done", 64'(b.done), 64'(exp_done));
            if (b.row_valid) begin
                if (row_q.size() == 0) begin
                    chk("row_unexpected", 64'(b.row_idx), 64'hDEAD);
                end else begin
                    row_t e;
                    e = row_q.pop_front();
                    chk("row_idx", 64'(b.row_idx), 64'(e.idx));
                    chk("row_out", 64'(b.row_out), 64'(e.val));
                    chk("row_time", 64'(m_cyc), 64'(e.cyc));
                end
            end
            if (b.done) begin
                if (cnt_q.size() == 0) chk("done_unexpected", 64'(b.counts), 64'hDEAD);
                else chk("final_counts", 64'(b.counts), 64'(cnt_q.pop_front()));
            end
            if (!exp_busy) chk("counts_hold", 64'(b.counts), 64'(m_counts));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_eval) b.eval_in = 4'($urandom);
        end
    endtask

    task automatic wr(input logic [3:0] sel, input logic [15:0] data);
        b.cfg_we = 1'b1; b.cfg_sel = sel; b.cfg_data = data;
        cyc(1);
        b.cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        b.start = 1'b1;
        cyc(1);
        b.start = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 60; i++) begin
            cyc(1);
            if (b.done === 1'b1) break;
        end
        if (i == 60) chk("wait_done_timeout", 64'(i), 64'(0));
    endtask

    task automatic wait_row(input int r);
        int i;
        for (i = 0; i < 60; i++) begin
            cyc(1);
            if (b.row_valid === 1'b1 && int'(b.row_idx) == r) break;
        end
        if (i == 60) chk("wait_row_timeout", 64'(i), 64'(r));
    endtask

    task automatic async_reset_check(input string tag);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk({tag, "_eval_out"}, 64'(b.eval_out), 64'(0));
        chk({tag, "_busy"}, 64'(b.busy), 64'(0));
        chk({tag, "_row_valid"}, 64'(b.row_valid), 64'(0));
        chk({tag, "_row_idx"}, 64'(b.row_idx), 64'(0));
        chk({tag, "_row_out"}, 64'(b.row_out), 64'(0));
        chk({tag, "_done"}, 64'(b.done), 64'(0));
        chk({tag, "_counts"}, 64'(b.counts), 64'(0));
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int i;
        b.cfg_we = 1'b0; b.cfg_sel = '0; b.cfg_data = '0; b.start = 1'b0; b.eval_in = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        cyc(3);
        #2 rst_n = 1'b1;
        async_reset_check("reset");

        // Empty-table sweep, with done latency measured from the start edge.
        cyc(2);
        pulse_start();
        for (i = 1; i <= 40; i++) begin
            cyc(1);
            if (b.done === 1'b1) break;
        end
        chk("done_latency", 64'(i), 64'(16));
        chk("empty_counts", 64'(b.counts), 64'(0));
        cyc(2);

        // Programmed functions.
        wr(4, 16'h8888);
        wr(5, 16'h111F);
        wr(9, 16'h6996);
        pulse_start();
        wait_row(7);
        chk("row7_bits_9_5_4", 64'({b.row_out[9], b.row_out[5], b.row_out[4]}), 64'(3'b101));
        wait_done();
        chk("count4", 64'(b.counts[4*CW +: CW]), 64'(4));
        chk("count5", 64'(b.counts[5*CW +: CW]), 64'(7));
        chk("count9", 64'(b.counts[9*CW +: CW]), 64'(8));
        chk("count0", 64'(b.counts[0*CW +: CW]), 64'(0));
        cyc(2);

        // Direct evaluation.
        rand_eval = 1'b0;
        b.eval_in = 4'b0111; cyc(1);
        chk("eval_0111", 64'(b.eval_out), 64'(10'b10_0001_0000));
        b.eval_in = 4'b0000; cyc(1);
        chk("eval_0000", 64'(b.eval_out), 64'(10'b00_0010_0000));
        rand_eval = 1'b1;

        // Busy protection: start and write in the middle of a sweep.
        pulse_start();
        wait_row(5);
        b.start = 1'b1; b.cfg_we = 1'b1; b.cfg_sel = 4'd4; b.cfg_data = 16'hFFFF;
        cyc(1);
        b.start = 1'b0; b.cfg_we = 1'b0;
        wait_done();
        chk("busy_count4", 64'(b.counts[4*CW +: CW]), 64'(4));
        cyc(1);
        pulse_start();
        wait_done();
        chk("confirm_count4", 64'(b.counts[4*CW +: CW]), 64'(4));
        cyc(2);

        // Reset in the middle of a sweep, then reprogram and sweep again.
        pulse_start();
        wait_row(5);
        async_reset_check("midsweep");
        cyc(1);
        wr(2, 16'($urandom));
        wr(7, 16'($urandom));
        wr(4, 16'h8888);
        pulse_start();
        wait_done();
        cyc(2);

        // Out-of-range select, then simultaneous write and start.
        wr(12, 16'hFFFF);
        pulse_start();
        wait_done();
        cyc(1);
        b.cfg_we = 1'b1; b.cfg_sel = 4'd0; b.cfg_data = 16'hFFFF; b.start = 1'b1;
        cyc(1);
        b.cfg_we = 1'b0; b.start = 1'b0;
        wait_done();
        chk("simul_count0", 64'(b.counts[0*CW +: CW]), 64'(16));
        cyc(2);

        // start held high re-arms one cycle after done.
        b.start = 1'b1;
        wait_done();
        cyc(1);
        chk("rearm_busy", 64'(b.busy), 64'(1));
        wait_done();
        b.start = 1'b0;
        cyc(3);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            b.cfg_we   = ($urandom_range(0, 3) == 0);
            b.cfg_sel  = 4'($urandom_range(0, 15));
            b.cfg_data = 16'($urandom);
            b.start    = ($urandom_range(0, 19) == 0);
            cyc(1);
        end
        b.cfg_we = 1'b0; b.start = 1'b0;
        cyc(40);
        chk("rows_drained", 64'(row_q.size()), 64'(0));
        chk("counts_drained", 64'(cnt_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
